// File: rtl/gpu_defines.sv
// Shared definitions for the GPU launch controller: register map, launch FSM states
// and AXI response codes.
package gpu_defines;

    // Word index of each register, taken from byte address bits [4:2]
    localparam logic [2:0] REG_CTRL            = 3'd0;
    localparam logic [2:0] REG_STATUS          = 3'd1;
    localparam logic [2:0] REG_BASE_INSTR      = 3'd2;
    localparam logic [2:0] REG_BASE_DATA       = 3'd3;
    localparam logic [2:0] REG_NUM_BLOCKS      = 3'd4;
    localparam logic [2:0] REG_WARPS_PER_BLOCK = 3'd5;
    localparam logic [2:0] REG_CYCLE_COUNT     = 3'd6;
    localparam logic [2:0] REG_LAUNCH_COUNT    = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        RST,
        RUN,
        DONE
    } launch_state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // Merge write data into a register image, byte lane by byte lane
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave front end: turns the AW/W/B and AR/R handshakes into single-cycle
// write and read strobes for a register file. One write outstanding at a time.
module axi_lite_slave_if
    import gpu_defines::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              wr_en,
    output logic [2:0]        wr_idx,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  axi_resp_t         wr_resp,
    output logic              rd_en,
    output logic [2:0]        rd_idx,
    input  logic [31:0]       rd_data
);

    logic        aw_held_q, aw_held_d;
    logic [2:0]  aw_idx_q;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q, bvalid_d;
    axi_resp_t   bresp_q;
    logic        awready_q, wready_q, arready_q;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q;
    logic        aw_hs, w_hs;

    // Only the word index is decoded; the remaining address bits are ignored
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr[ADDR_W-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[ADDR_W-1:5], s_axi_araddr[1:0]};

    // Handshake decode and next-state for the holding slots and response channels
    always_comb begin
        aw_hs     = s_axi_awvalid & awready_q;
        w_hs      = s_axi_wvalid & wready_q;
        // Commit once both halves sit in their slots
        wr_en     = aw_held_q & w_held_q;
        aw_held_d = wr_en ? 1'b0 : (aw_held_q | aw_hs);
        w_held_d  = wr_en ? 1'b0 : (w_held_q | w_hs);
        bvalid_d  = wr_en | (bvalid_q & ~s_axi_bready);
        rd_en     = s_axi_arvalid & arready_q;
        rvalid_d  = rd_en | (rvalid_q & ~s_axi_rready);
    end

    // Slot, response and ready registers; readies are registered so they read 0 in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            awready_q <= ~aw_held_d & ~bvalid_d;
            wready_q  <= ~w_held_d & ~bvalid_d;
            arready_q <= ~rvalid_d;
            if (aw_hs) begin
                aw_idx_q <= s_axi_awaddr[4:2];
            end
            if (w_hs) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (wr_en) begin
                bresp_q <= wr_resp;
            end
            if (rd_en) begin
                rdata_q <= rd_data;
            end
        end
    end

    assign wr_idx        = aw_idx_q;
    assign wr_data       = w_data_q;
    assign wr_strb       = w_strb_q;
    assign rd_idx        = s_axi_araddr[4:2];
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: rtl/gpu_launch_ctrl.sv
// GPU launch controller: AXI4-Lite register file holding the kernel launch config,
// plus the FSM that resets the GPU, runs it until done and records status/counters.
module gpu_launch_ctrl
    import gpu_defines::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              gpu_reset,
    output logic [31:0]       base_instr,
    output logic [31:0]       base_data,
    output logic [31:0]       num_blocks,
    output logic [31:0]       warps_per_block,
    output logic              execution_start,
    input  logic              execution_done,
    output logic              irq
);

    localparam int unsigned RstCntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic          wr_en, rd_en;
    logic [2:0]    wr_idx, rd_idx;
    logic [31:0]   wr_data, rd_data;
    logic [3:0]    wr_strb;
    axi_resp_t     wr_resp;

    launch_state_t state_q;
    logic [RstCntW-1:0] rst_cnt_q;
    logic          gpu_reset_q, exec_start_q;
    logic [31:0]   cycle_cnt_q, launch_cnt_q;
    logic          irq_en_q, done_sticky_q;
    logic [31:0]   base_instr_q, base_data_q, num_blocks_q, warps_q;

    logic busy, ctrl_wr, status_wr, cfg_wr, start_req, start_launch, start_zero, done_set;

    // rdata is registered inside the interface, so the read strobe itself is not needed here
    logic unused_rd_en;
    assign unused_rd_en = rd_en;

    axi_lite_slave_if #(
        .ADDR_W (ADDR_W)
    ) u_axi_if (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_resp       (wr_resp),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .rd_data       (rd_data)
    );

    // Write decode, launch request and write response
    always_comb begin
        busy         = (state_q != IDLE);
        ctrl_wr      = wr_en && (wr_idx == REG_CTRL);
        status_wr    = wr_en && (wr_idx == REG_STATUS);
        cfg_wr       = wr_en && (wr_idx inside {REG_BASE_INSTR, REG_BASE_DATA,
                                                REG_NUM_BLOCKS, REG_WARPS_PER_BLOCK});
        start_req    = ctrl_wr && wr_strb[0] && wr_data[0];
        start_launch = start_req && !busy && (num_blocks_q != '0);
        // An empty grid completes on the spot without touching the GPU
        start_zero   = start_req && !busy && (num_blocks_q == '0);
        done_set     = (state_q == DONE) || start_zero;
        wr_resp      = ((start_req || cfg_wr) && busy) ? RESP_SLVERR : RESP_OKAY;
    end

    // Read mux; sampled by the interface on the AR handshake
    always_comb begin
        rd_data = '0;
        case (rd_idx)
            REG_CTRL:            rd_data = {30'd0, irq_en_q, 1'b0};
            REG_STATUS:          rd_data = {30'd0, done_sticky_q, busy};
            REG_BASE_INSTR:      rd_data = base_instr_q;
            REG_BASE_DATA:       rd_data = base_data_q;
            REG_NUM_BLOCKS:      rd_data = num_blocks_q;
            REG_WARPS_PER_BLOCK: rd_data = warps_q;
            REG_CYCLE_COUNT:     rd_data = cycle_cnt_q;
            REG_LAUNCH_COUNT:    rd_data = launch_cnt_q;
            default:             rd_data = '0;
        endcase
    end

    // Host-writable registers; config is frozen while a launch is in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q      <= 1'b0;
            done_sticky_q <= 1'b0;
            base_instr_q  <= '0;
            base_data_q   <= '0;
            num_blocks_q  <= '0;
            warps_q       <= '0;
        end else begin
            if (ctrl_wr && wr_strb[0]) begin
                irq_en_q <= wr_data[1];
            end
            // Hardware set beats a same-cycle W1C
            if (done_set) begin
                done_sticky_q <= 1'b1;
            end else if (status_wr && wr_strb[0] && wr_data[1]) begin
                done_sticky_q <= 1'b0;
            end
            if (cfg_wr && !busy) begin
                case (wr_idx)
                    REG_BASE_INSTR:      base_instr_q <= apply_wstrb(base_instr_q, wr_data, wr_strb);
                    REG_BASE_DATA:       base_data_q  <= apply_wstrb(base_data_q, wr_data, wr_strb);
                    REG_NUM_BLOCKS:      num_blocks_q <= apply_wstrb(num_blocks_q, wr_data, wr_strb);
                    REG_WARPS_PER_BLOCK: warps_q      <= apply_wstrb(warps_q, wr_data, wr_strb);
                    default: ;
                endcase
            end
        end
    end

    // Launch sequencer with registered GPU control outputs and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            gpu_reset_q  <= 1'b1;
            exec_start_q <= 1'b0;
            cycle_cnt_q  <= '0;
            launch_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_launch) begin
                        state_q     <= RST;
                        rst_cnt_q   <= RstCntW'(RESET_CYCLES - 1);
                        cycle_cnt_q <= '0;
                    end
                end
                RST: begin
                    if (rst_cnt_q == '0) begin
                        state_q      <= RUN;
                        gpu_reset_q  <= 1'b0;
                        exec_start_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                        cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    end
                    if (execution_done) begin
                        state_q      <= DONE;
                        exec_start_q <= 1'b0;
                    end
                end
                DONE: begin
                    launch_cnt_q <= launch_cnt_q + 32'd1;
                    gpu_reset_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gpu_reset       = gpu_reset_q;
    assign execution_start = exec_start_q;
    assign base_instr      = base_instr_q;
    assign base_data       = base_data_q;
    assign num_blocks      = num_blocks_q;
    assign warps_per_block = warps_q;
    assign irq             = done_sticky_q & irq_en_q;

endmodule
